// File: rtl/counter_pkg.sv
// Shared constants for the modulo up/down counter family.
package counter_pkg;

  localparam logic DIR_DOWN = 1'b0;
  localparam logic DIR_UP   = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_mod_ud_if.sv
// Control/status bundle between the maze controller and one counter instance.
interface counter_mod_ud_if #(
    parameter int WIDTH = 4
);
    // Control strobes are level-sampled on every rising clk edge; there is no
    // handshake, the counter acts on whatever is presented at the edge.
    logic             rstcnt;
    logic             ldcnt;
    logic             enCnt;
    logic             upDown;
    logic [WIDTH-1:0] parIn;
    logic [WIDTH-1:0] cnt;
    logic             carryOut;
    logic             borrowOut;
    logic             tc;

    modport master (
        output rstcnt, ldcnt, enCnt, upDown, parIn,
        input  cnt, carryOut, borrowOut, tc
    );

    modport slave (
        input  rstcnt, ldcnt, enCnt, upDown, parIn,
        output cnt, carryOut, borrowOut, tc
    );
endinterface

// File: rtl/counter_next_val.sv
// Combinational next-count logic for one enabled step, with wrap/saturate and
// boundary event detection.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             upDown,
    output logic [WIDTH-1:0] next_cnt,
    output logic             carry_evt,
    output logic             borrow_evt
);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH:0] cntExt;
    logic [WIDTH:0] incExt;
    logic [WIDTH:0] decExt;

    // One extra bit keeps MAX_VAL = 2**WIDTH-1 distinguishable from a wrap.
    always_comb begin
        cntExt     = {1'b0, cnt};
        incExt     = cntExt + (WIDTH+1)'(1);
        decExt     = cntExt - (WIDTH+1)'(1);
        next_cnt   = cnt;
        carry_evt  = 1'b0;
        borrow_evt = 1'b0;
        if (upDown == DIR_UP) begin
            if (incExt > MAX_EXT) begin
                carry_evt = 1'b1;
                next_cnt  = (SATURATE == MODE_SAT) ? MAX_CNT : '0;
            end else begin
                next_cnt = incExt[WIDTH-1:0];
            end
        end else begin
            if (decExt[WIDTH]) begin
                borrow_evt = 1'b1;
                next_cnt   = (SATURATE == MODE_SAT) ? '0 : MAX_CNT;
            end else begin
                next_cnt = decExt[WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/counter_mod_ud.sv
// WIDTH-bit modulo-MAX_VAL up/down counter with clear, clamped load,
// wrap/saturate mode, registered carry/borrow pulses and a live terminal count.
module counter_mod_ud
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP
) (
    input logic              clk,
    input logic              rst,
    counter_mod_ud_if.slave  bus
);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] cntQ;
    logic             carryQ;
    logic             borrowQ;
    logic [WIDTH-1:0] nextCnt;
    logic             carryEvt;
    logic             borrowEvt;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cnt        (cntQ),
        .upDown     (bus.upDown),
        .next_cnt   (nextCnt),
        .carry_evt  (carryEvt),
        .borrow_evt (borrowEvt)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.rstcnt) begin
            cntQ    <= '0;
            carryQ  <= 1'b0;
            borrowQ <= 1'b0;
        end else if (bus.ldcnt) begin
            // Out-of-range loads clamp so the count never leaves 0..MAX_VAL.
            cntQ    <= ({1'b0, bus.parIn} > MAX_EXT) ? MAX_CNT : bus.parIn;
            carryQ  <= 1'b0;
            borrowQ <= 1'b0;
        end else if (bus.enCnt) begin
            cntQ    <= nextCnt;
            carryQ  <= carryEvt;
            borrowQ <= borrowEvt;
        end else begin
            carryQ  <= 1'b0;
            borrowQ <= 1'b0;
        end
    end

    assign bus.cnt       = cntQ;
    assign bus.carryOut  = carryQ;
    assign bus.borrowOut = borrowQ;
    assign bus.tc        = (bus.upDown == DIR_UP) ? (cntQ == MAX_CNT) : (cntQ == '0);
endmodule

// File: tb/tb_counter_mod_ud.sv
// Directed bench for counter_mod_ud: wrap, saturate and small-width instances.
module tb_counter_mod_ud;
    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;

    counter_mod_ud_if #(.WIDTH(4)) ifA ();
    counter_mod_ud_if #(.WIDTH(4)) ifB ();
    counter_mod_ud_if #(.WIDTH(2)) ifC ();

    counter_mod_ud #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dutA (.clk(clk), .rst(rst), .bus(ifA));
    counter_mod_ud #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dutB (.clk(clk), .rst(rst), .bus(ifB));
    counter_mod_ud #(.WIDTH(2), .MAX_VAL(3), .SATURATE(0)) dutC (.clk(clk), .rst(rst), .bus(ifC));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b0;
        nChecks += 3;
        if (ifA.cnt !== 4'd0 || ifA.carryOut !== 1'b0 || ifA.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL reset_a: cnt=%0d c=%b b=%b, required 0 0 0", ifA.cnt, ifA.carryOut, ifA.borrowOut);
        end
        if (ifB.cnt !== 4'd0 || ifB.carryOut !== 1'b0 || ifB.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL reset_b: cnt=%0d c=%b b=%b, required 0 0 0", ifB.cnt, ifB.carryOut, ifB.borrowOut);
        end
        if (ifC.cnt !== 2'd0 || ifC.carryOut !== 1'b0 || ifC.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL reset_c: cnt=%0d c=%b b=%b, required 0 0 0", ifC.cnt, ifC.carryOut, ifC.borrowOut);
        end
    endtask

    task automatic test_count_up();
        int expSeq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        ifA.enCnt  = 1'b1;
        ifA.upDown = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            nChecks++;
            if (ifA.cnt !== 4'(expSeq[i]) || ifA.carryOut !== (expSeq[i] == 0) ||
                ifA.borrowOut !== 1'b0 || ifA.tc !== (expSeq[i] == 9)) begin
                nFails++;
                $display("FAIL count_up[%0d]: cnt=%0d c=%b b=%b tc=%b, required cnt=%0d c=%b b=0 tc=%b",
                         i, ifA.cnt, ifA.carryOut, ifA.borrowOut, ifA.tc,
                         expSeq[i], (expSeq[i] == 0), (expSeq[i] == 9));
            end
        end
        ifA.enCnt = 1'b0;
    endtask

    task automatic test_count_down();
        int expSeq[4] = '{1, 0, 9, 8};
        ifA.ldcnt = 1'b1;
        ifA.parIn = 4'd2;
        tick();
        ifA.ldcnt  = 1'b0;
        ifA.upDown = 1'b0;
        nChecks++;
        if (ifA.cnt !== 4'd2 || ifA.carryOut !== 1'b0 || ifA.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL load_2: cnt=%0d c=%b b=%b, required 2 0 0", ifA.cnt, ifA.carryOut, ifA.borrowOut);
        end
        ifA.enCnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks++;
            if (ifA.cnt !== 4'(expSeq[i]) || ifA.borrowOut !== (expSeq[i] == 9) ||
                ifA.carryOut !== 1'b0 || ifA.tc !== (expSeq[i] == 0)) begin
                nFails++;
                $display("FAIL count_down[%0d]: cnt=%0d c=%b b=%b tc=%b, required cnt=%0d c=0 b=%b tc=%b",
                         i, ifA.cnt, ifA.carryOut, ifA.borrowOut, ifA.tc,
                         expSeq[i], (expSeq[i] == 9), (expSeq[i] == 0));
            end
        end
        ifA.enCnt = 1'b0;
    endtask

    task automatic test_saturate();
        logic expCarry[3] = '{1'b0, 1'b1, 1'b1};
        ifB.ldcnt = 1'b1;
        ifB.parIn = 4'd8;
        tick();
        ifB.ldcnt  = 1'b0;
        ifB.enCnt  = 1'b1;
        ifB.upDown = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (ifB.cnt !== 4'd9 || ifB.carryOut !== expCarry[i] || ifB.borrowOut !== 1'b0) begin
                nFails++;
                $display("FAIL sat_up[%0d]: cnt=%0d c=%b b=%b, required cnt=9 c=%b b=0",
                         i, ifB.cnt, ifB.carryOut, ifB.borrowOut, expCarry[i]);
            end
        end
        ifB.enCnt = 1'b0;
        ifB.ldcnt = 1'b1;
        ifB.parIn = 4'd0;
        tick();
        ifB.ldcnt  = 1'b0;
        ifB.enCnt  = 1'b1;
        ifB.upDown = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nChecks++;
            if (ifB.cnt !== 4'd0 || ifB.borrowOut !== 1'b1 || ifB.carryOut !== 1'b0 || ifB.tc !== 1'b1) begin
                nFails++;
                $display("FAIL sat_down[%0d]: cnt=%0d c=%b b=%b tc=%b, required cnt=0 c=0 b=1 tc=1",
                         i, ifB.cnt, ifB.carryOut, ifB.borrowOut, ifB.tc);
            end
        end
        ifB.enCnt = 1'b0;
        tick();
        nChecks++;
        if (ifB.cnt !== 4'd0 || ifB.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL sat_release: cnt=%0d b=%b, required cnt=0 b=0", ifB.cnt, ifB.borrowOut);
        end
    endtask

    task automatic test_load_clamp();
        ifA.ldcnt = 1'b1;
        ifA.parIn = 4'hE;
        tick();
        nChecks++;
        if (ifA.cnt !== 4'd9 || ifA.carryOut !== 1'b0 || ifA.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL load_clamp: cnt=%0d c=%b b=%b, required 9 0 0", ifA.cnt, ifA.carryOut, ifA.borrowOut);
        end
        ifA.enCnt  = 1'b1;
        ifA.upDown = 1'b1;
        ifA.parIn  = 4'd3;
        tick();
        ifA.ldcnt = 1'b0;
        ifA.enCnt = 1'b0;
        nChecks++;
        if (ifA.cnt !== 4'd3 || ifA.carryOut !== 1'b0 || ifA.tc !== 1'b0) begin
            nFails++;
            $display("FAIL load_over_en: cnt=%0d c=%b tc=%b, required cnt=3 c=0 tc=0", ifA.cnt, ifA.carryOut, ifA.tc);
        end
    endtask

    task automatic test_mid_clear();
        ifA.ldcnt = 1'b1;
        ifA.parIn = 4'd5;
        tick();
        ifA.enCnt  = 1'b1;
        ifA.upDown = 1'b1;
        ifA.rstcnt = 1'b1;
        ifA.parIn  = 4'd7;
        tick();
        ifA.rstcnt = 1'b0;
        ifA.enCnt  = 1'b0;
        ifA.parIn  = 4'd5;
        nChecks++;
        if (ifA.cnt !== 4'd0 || ifA.carryOut !== 1'b0 || ifA.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL rstcnt_wins: cnt=%0d c=%b b=%b, required 0 0 0", ifA.cnt, ifA.carryOut, ifA.borrowOut);
        end
        tick();
        ifA.ldcnt = 1'b0;
        nChecks++;
        if (ifA.cnt !== 4'd5) begin
            nFails++;
            $display("FAIL reload_5: cnt=%0d, required 5", ifA.cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nChecks++;
        if (ifA.cnt !== 4'd5) begin
            nFails++;
            $display("FAIL rst_sync_hold: cnt=%0d, required 5 before edge", ifA.cnt);
        end
        tick();
        rst = 1'b0;
        nChecks++;
        if (ifA.cnt !== 4'd0) begin
            nFails++;
            $display("FAIL rst_sync_edge: cnt=%0d, required 0", ifA.cnt);
        end
    endtask

    task automatic test_wrap_small();
        ifC.ldcnt  = 1'b1;
        ifC.parIn  = 2'd3;
        ifC.upDown = 1'b1;
        tick();
        ifC.ldcnt = 1'b0;
        nChecks++;
        if (ifC.cnt !== 2'd3 || ifC.tc !== 1'b1) begin
            nFails++;
            $display("FAIL small_load: cnt=%0d tc=%b, required cnt=3 tc=1", ifC.cnt, ifC.tc);
        end
        ifC.enCnt = 1'b1;
        tick();
        ifC.enCnt = 1'b0;
        nChecks++;
        if (ifC.cnt !== 2'd0 || ifC.carryOut !== 1'b1 || ifC.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL small_wrap: cnt=%0d c=%b b=%b, required 0 1 0", ifC.cnt, ifC.carryOut, ifC.borrowOut);
        end
        tick();
        nChecks++;
        if (ifC.cnt !== 2'd0 || ifC.carryOut !== 1'b0) begin
            nFails++;
            $display("FAIL small_hold: cnt=%0d c=%b, required 0 0", ifC.cnt, ifC.carryOut);
        end
    endtask

    task automatic test_back_to_back();
        ifA.ldcnt = 1'b1;
        ifA.parIn = 4'd0;
        tick();
        ifA.ldcnt  = 1'b0;
        ifA.enCnt  = 1'b1;
        ifA.upDown = 1'b1;
        tick();
        nChecks++;
        if (ifA.cnt !== 4'd1 || ifA.tc !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_up: cnt=%0d tc=%b, required 1 0", ifA.cnt, ifA.tc);
        end
        ifA.upDown = 1'b0;
        tick();
        nChecks++;
        if (ifA.cnt !== 4'd0 || ifA.tc !== 1'b1 || ifA.borrowOut !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_down: cnt=%0d tc=%b b=%b, required 0 1 0", ifA.cnt, ifA.tc, ifA.borrowOut);
        end
        tick();
        ifA.enCnt = 1'b0;
        nChecks++;
        if (ifA.cnt !== 4'd9 || ifA.borrowOut !== 1'b1 || ifA.carryOut !== 1'b0) begin
            nFails++;
            $display("FAIL b2b_underflow: cnt=%0d c=%b b=%b, required 9 0 1", ifA.cnt, ifA.carryOut, ifA.borrowOut);
        end
        ifA.upDown = 1'b1;
        #1;
        nChecks++;
        if (ifA.tc !== 1'b1) begin
            nFails++;
            $display("FAIL tc_comb: tc=%b, required 1", ifA.tc);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rst     = 1'b1;
        ifA.rstcnt = 1'b0; ifA.ldcnt = 1'b0; ifA.enCnt = 1'b0; ifA.upDown = 1'b0; ifA.parIn = '0;
        ifB.rstcnt = 1'b0; ifB.ldcnt = 1'b0; ifB.enCnt = 1'b0; ifB.upDown = 1'b0; ifB.parIn = '0;
        ifC.rstcnt = 1'b0; ifC.ldcnt = 1'b0; ifC.enCnt = 1'b0; ifC.upDown = 1'b0; ifC.parIn = '0;
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clamp();
        test_mid_clear();
        test_wrap_small();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/counter_mod_ud.md
Name: counter_mod_ud

Overview:
- Parametrised successor of the team's 2-bit loadable counter: WIDTH-bit, modulo-MAX_VAL, up/down counter.
- Provides synchronous clear, parallel load, wrap or saturate mode, registered carry/borrow pulses and a combinational terminal-count flag.
- Used by the maze controller datapath for row/column indices, move-direction stepping and stack-pointer style up/down indexing.

Parameters:
- WIDTH, 4: counter width in bits (≥1).
- MAX_VAL, 2**WIDTH-1: highest count value; counter range is 0..MAX_VAL; must be ≤ 2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rstcnt  in  1  synchronous clear request from the controller.
- ldcnt  in  1  parallel load strobe.
- enCnt  in  1  count enable.
- upDown  in  1  1 = count up, 0 = count down.
- parIn  in  WIDTH  parallel load value.
- cnt  out  WIDTH  registered count.
- carryOut  out  1  registered one-cycle pulse on an up-step past MAX_VAL.
- borrowOut  out  1  registered one-cycle pulse on a down-step below 0.
- tc  out  1  combinational terminal count: (upDown && cnt==MAX_VAL) || (!upDown && cnt==0).

Behaviour:
- Reset is synchronous and active-high: rst sampled high at a rising clk edge gives cnt=0, carryOut=0, borrowOut=0 at that edge. There is no asynchronous path.
- Priority per edge: rst > rstcnt > ldcnt > enCnt > hold.
- rstcnt: identical effect to rst (cnt=0, both flags 0).
- ldcnt:
  - cnt <= parIn if parIn ≤ MAX_VAL; otherwise cnt <= MAX_VAL (clamped).
  - carryOut and borrowOut are 0.
  - upDown and enCnt are ignored.
- enCnt with upDown=1:
  - cnt < MAX_VAL: cnt+1, flags 0.
  - cnt == MAX_VAL, SATURATE=0: cnt <= 0, carryOut=1.
  - cnt == MAX_VAL, SATURATE=1: cnt holds at MAX_VAL, carryOut=1 (overflow attempt still reported).
- enCnt with upDown=0:
  - cnt > 0: cnt-1, flags 0.
  - cnt == 0, SATURATE=0: cnt <= MAX_VAL, borrowOut=1.
  - cnt == 0, SATURATE=1: cnt holds at 0, borrowOut=1.
- Hold (no enable/load/clear): cnt unchanged. carryOut and borrowOut return to 0, so each flag is a one-cycle pulse per event.
- Latency:
  - cnt and the flags update one edge after the sampled controls.
  - tc reflects the current cnt and upDown with zero latency.
  - When tc is high and enCnt is high, the next edge produces the wrap/hold and its flag pulse.
- carryOut and borrowOut are never both 1.
- Arithmetic:
  - The next-value compare and increment are done at WIDTH+1 bits, so MAX_VAL = 2**WIDTH-1 wraps correctly without relying on natural overflow.
  - cnt never holds a value > MAX_VAL.
- Direction change takes effect on the same edge it is sampled; there is no pipeline state.
- rst or rstcnt asserted mid-count, or together with ldcnt/enCnt, wins and clears everything on that edge.
- Non-blocking assignment only; no latches; all outputs are driven from flops except tc.

Decomposition:
- Shared package counter_pkg:
  - localparams DIR_DOWN=1'b0 and DIR_UP=1'b1.
  - MODE_WRAP=0 and MODE_SAT=1 for the SATURATE parameter.
- One natural sub-module, counter_next_val: purely combinational. Takes cnt and upDown, plus the WIDTH, MAX_VAL and SATURATE parameters. Returns next_cnt, carry_evt and borrow_evt.
- The top module holds the register, the priority mux and tc.

Test Plan:
1. WIDTH=4, MAX_VAL=9, SATURATE=0; rst for 1 cycle, then enCnt=1, upDown=1 for 12 cycles -> cnt sequence 1..9,0,1,2; carryOut=1 only in the cycle cnt shows 0; tc=1 while cnt=9.
2. Same config; ldcnt=1, parIn=2, then enCnt=1, upDown=0 for 4 cycles -> cnt 2,1,0,9,8; borrowOut=1 only with cnt=9; tc=1 while cnt=0.
3. SATURATE=1, MAX_VAL=9; load 8, count up 3 cycles -> cnt 9,9,9; carryOut=1 on the 2nd and 3rd edges; then count down from 0 -> cnt 0 held, borrowOut=1.
4. Load out of range: parIn=4'hE with MAX_VAL=9 -> cnt=9, flags 0; ldcnt=1 and enCnt=1 together with parIn=3 -> cnt=3 (load wins).
5. Mid-count clear: cnt=5 with enCnt=1; assert rstcnt and ldcnt=1 (parIn=7) on the same edge -> cnt=0, flags 0. Assert rst between clock edges -> no change until the next rising clk edge.
6. WIDTH=2, MAX_VAL=3, SATURATE=0: count up from 3 -> cnt=0 with carryOut=1. Hold for 1 cycle -> carryOut drops to 0 and cnt stays 0.
